// File: rtl/rom_bus_pkg.sv
// rom_bus_pkg: shared types and constants for the program-ROM bus slave.
//   rom_bus_state_t : bus-cycle FSM states
//   ROM_REGION_TAG  : value of addr[22:19] that selects the ROM region
//   HROM_SEL_BIT    : word-address bit selecting high ROM over low ROM
//   DEF_*           : default widths
package rom_bus_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } rom_bus_state_t;

  localparam logic [3:0] ROM_REGION_TAG = 4'h0;
  localparam int         HROM_SEL_BIT   = 18;

  localparam int DEF_HROM_AW = 12;
  localparam int DEF_LROM_AW = 17;
  localparam int ADDR_W      = 23;
  localparam int DATA_W      = 16;
  localparam int WCNT_W      = 4;

  function automatic logic region_hit(input logic [ADDR_W-1:0] a);
    return a[22:19] == ROM_REGION_TAG;
  endfunction
endpackage

// File: rtl/rom_wait_ctr.sv
// rom_wait_ctr: loadable down-counter used to stretch the acknowledge.
//   clk, rst_b : clock, async active-low reset
//   load       : load load_val (wins over dec)
//   load_val   : value loaded
//   dec        : decrement, saturating at zero
//   done       : count is zero
module rom_wait_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/rom_bus_ctrl.sv
// rom_bus_ctrl: 68010 bus slave for the on-chip program ROMs.
// Decodes the ROM region, drives the synchronous BRAM address/enable,
// stretches the cycle by WAIT_STATES and acknowledges with a full
// four-phase DTACK_b/AS_b handshake.
//   clk, rst_b            : clock, async active-low reset
//   AS_b, UDS_b, LDS_b    : address / data strobes (active low)
//   BR_W_b                : 1 = read, 0 = write
//   addr                  : word address A23:A1
//   hrom_q, lrom_q        : BRAM read data (valid 1 cycle after rom_en)
//   hrom_addr, lrom_addr  : BRAM addresses (latched at cycle start)
//   rom_en                : single-cycle BRAM read enable
//   MD_out                : read data to CPU
//   DTACK_b               : data acknowledge (active low)
//   rom_sel               : ROM cycle in progress
//   wr_trap               : sticky write-to-ROM flag
// Optional feature: define ROM_WRITE_TRAP_EN to build the write trap;
// otherwise wr_trap is tied low.
module rom_bus_ctrl
  import rom_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int HROM_AW     = DEF_HROM_AW,
  parameter int LROM_AW     = DEF_LROM_AW
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               AS_b,
  input  logic               UDS_b,
  input  logic               LDS_b,
  input  logic               BR_W_b,
  input  logic [22:0]        addr,
  input  logic [15:0]        hrom_q,
  input  logic [15:0]        lrom_q,
  output logic [HROM_AW-1:0] hrom_addr,
  output logic [LROM_AW-1:0] lrom_addr,
  output logic               rom_en,
  output logic [15:0]        MD_out,
  output logic               DTACK_b,
  output logic               rom_sel,
  output logic               wr_trap
);
  // Counter holds WAIT_STATES-1 so that done marks the last WAIT cycle.
  localparam logic [WCNT_W-1:0] WS_LOAD =
    (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

  rom_bus_state_t state;
  logic           fetch_ph;   // 0: BRAM access in flight, 1: BRAM data valid
  logic           hsel;
  logic           is_wr;
  logic [15:0]    rd_data;
  logic           wait_done;
  logic           start;
  logic [15:0]    q_sel;

  assign start = !AS_b && region_hit(addr) && (!UDS_b || !LDS_b);
  assign q_sel = hsel ? hrom_q : lrom_q;

  rom_wait_ctr #(.W(WCNT_W)) u_wait_ctr (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (state == ST_FETCH && fetch_ph && !AS_b),
    .load_val (WS_LOAD),
    .dec      (state == ST_WAIT),
    .done     (wait_done)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= ST_IDLE;
      fetch_ph  <= 1'b0;
      hsel      <= 1'b0;
      is_wr     <= 1'b0;
      rd_data   <= '0;
      hrom_addr <= '0;
      lrom_addr <= '0;
      rom_en    <= 1'b0;
      MD_out    <= '0;
      DTACK_b   <= 1'b1;
      rom_sel   <= 1'b0;
    end else begin
      rom_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            fetch_ph  <= 1'b0;
            hsel      <= addr[HROM_SEL_BIT];
            is_wr     <= !BR_W_b;
            hrom_addr <= addr[HROM_AW-1:0];
            lrom_addr <= addr[LROM_AW-1:0];
            rom_en    <= 1'b1;
            rom_sel   <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (AS_b) begin
            state   <= ST_IDLE;
            rom_sel <= 1'b0;
          end else if (!fetch_ph) begin
            fetch_ph <= 1'b1;
          end else begin
            rd_data <= q_sel;
            if (WAIT_STATES > 0) begin
              state <= ST_WAIT;
            end else begin
              state   <= ST_ACK;
              DTACK_b <= 1'b0;
              if (!is_wr) MD_out <= q_sel;
            end
          end
        end
        ST_WAIT: begin
          if (AS_b) begin
            state   <= ST_IDLE;
            rom_sel <= 1'b0;
          end else if (wait_done) begin
            state   <= ST_ACK;
            DTACK_b <= 1'b0;
            if (!is_wr) MD_out <= rd_data;
          end
        end
        ST_ACK: begin
          // Leaving ACK always passes through IDLE, so back-to-back
          // cycles get at least one idle clock.
          if (AS_b) begin
            state   <= ST_IDLE;
            DTACK_b <= 1'b1;
            rom_sel <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ROM_WRITE_TRAP_EN
  // Trap fires on the first FETCH edge of a write that was not aborted.
  logic        wr_trap_r;
  logic [22:0] dbg_trap_addr;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_trap_r     <= 1'b0;
      dbg_trap_addr <= '0;
    end else if (state == ST_FETCH && !fetch_ph && !AS_b && is_wr && !wr_trap_r) begin
      wr_trap_r     <= 1'b1;
      dbg_trap_addr <= addr;
    end
  end

  assign wr_trap = wr_trap_r;
  logic unused_dbg;
  assign unused_dbg = ^dbg_trap_addr;
`else
  assign wr_trap = 1'b0;
`endif

  // Bits of addr outside the decode/BRAM fields are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^addr;
endmodule

// File: tb/tb_rom_bus_ctrl.sv
module tb_rom_bus_ctrl;
  localparam int N = 3;
`ifdef ROM_WRITE_TRAP_EN
  localparam logic TRAP_ON = 1'b1;
`else
  localparam logic TRAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        AS_b = 1'b1, UDS_b = 1'b1, LDS_b = 1'b1, BR_W_b = 1'b1;
  logic [22:0] addr = '0;

  logic [15:0] hrom_q [N];
  logic [15:0] lrom_q [N];
  logic [11:0] hrom_addr [N];
  logic [16:0] lrom_addr [N];
  logic        rom_en [N];
  logic [15:0] MD_out [N];
  logic        DTACK_b [N];
  logic        rom_sel [N];
  logic        wr_trap [N];

  always #5 clk = ~clk;

  // Instance 0: WAIT_STATES=0, 1: WAIT_STATES=1, 2: WAIT_STATES=3
  for (genvar g = 0; g < N; g++) begin : g_dut
    rom_bus_ctrl #(
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
      .HROM_AW(12), .LROM_AW(17)
    ) u_dut (
      .clk(clk), .rst_b(rst_b), .AS_b(AS_b), .UDS_b(UDS_b), .LDS_b(LDS_b),
      .BR_W_b(BR_W_b), .addr(addr), .hrom_q(hrom_q[g]), .lrom_q(lrom_q[g]),
      .hrom_addr(hrom_addr[g]), .lrom_addr(lrom_addr[g]), .rom_en(rom_en[g]),
      .MD_out(MD_out[g]), .DTACK_b(DTACK_b[g]), .rom_sel(rom_sel[g]),
      .wr_trap(wr_trap[g])
    );
  end

  // ROM contents
  function automatic logic [15:0] hval(input logic [11:0] a);
    return (a == 12'hFFF) ? 16'h4E75 : {4'hC, a};
  endfunction
  function automatic logic [15:0] lval(input logic [16:0] a);
    return (a == 17'h00123) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  // Synchronous BRAMs: registered output on rom_en
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (rom_en[i]) begin
        hrom_q[i] <= hval(hrom_addr[i]);
        lrom_q[i] <= lval(lrom_addr[i]);
      end
  end

  // Reference model: cycle timestamps relative to the start edge
  int          ws [N] = '{0, 1, 3};
  bit          m_busy [N], m_ack [N], m_wr [N], m_hsel [N];
  int          m_age [N];
  bit          m_en [N], m_sel [N], m_trap [N], m_dtack [N];
  logic [15:0] m_md [N];
  logic [11:0] m_ha [N];
  logic [16:0] m_la [N];

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (!rst_b) begin
        m_busy[i] = 0; m_ack[i] = 0; m_wr[i] = 0; m_hsel[i] = 0; m_age[i] = 0;
        m_en[i] = 0; m_sel[i] = 0; m_trap[i] = 0; m_dtack[i] = 1;
        m_md[i] = '0; m_ha[i] = '0; m_la[i] = '0;
      end else begin
        m_en[i] = 0;
        if (!m_busy[i]) begin
          if (!AS_b && addr[22:19] == 4'h0 && (!UDS_b || !LDS_b)) begin
            m_busy[i] = 1; m_ack[i] = 0; m_age[i] = 0; m_wr[i] = !BR_W_b;
            m_hsel[i] = addr[18]; m_ha[i] = addr[11:0]; m_la[i] = addr[16:0];
            m_en[i] = 1; m_sel[i] = 1;
          end
        end else if (!m_ack[i]) begin
          if (AS_b) begin
            m_busy[i] = 0; m_sel[i] = 0;
          end else begin
            m_age[i]++;
            if (m_age[i] == 1 && m_wr[i] && TRAP_ON) m_trap[i] = 1;
            if (m_age[i] == 2 + ws[i]) begin
              m_ack[i] = 1; m_dtack[i] = 0;
              if (!m_wr[i]) m_md[i] = m_hsel[i] ? hval(m_ha[i]) : lval(m_la[i]);
            end
          end
        end else if (AS_b) begin
          m_busy[i] = 0; m_ack[i] = 0; m_dtack[i] = 1; m_sel[i] = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_b);
    model_step();
  end

  int nvec = 0, nerr = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d] @%0t got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_on)
      for (int i = 0; i < N; i++) begin
        chk("dtack", i, 32'(DTACK_b[i]), 32'(m_dtack[i]));
        chk("rom_sel", i, 32'(rom_sel[i]), 32'(m_sel[i]));
        chk("rom_en", i, 32'(rom_en[i]), 32'(m_en[i]));
        chk("wr_trap", i, 32'(wr_trap[i]), 32'(m_trap[i]));
        chk("hrom_addr", i, 32'(hrom_addr[i]), 32'(m_ha[i]));
        chk("lrom_addr", i, 32'(lrom_addr[i]), 32'(m_la[i]));
        chk("md_out", i, 32'(MD_out[i]), 32'(m_md[i]));
      end
  end

  task automatic drive(input logic [22:0] a, input logic rd);
    addr = a; BR_W_b = rd; UDS_b = 1'b0; LDS_b = 1'b0; AS_b = 1'b0;
  endtask
  task automatic release_bus();
    AS_b = 1'b1; UDS_b = 1'b1; LDS_b = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_dtack", i, 32'(DTACK_b[i]), 32'h1);
      chk("rst_md", i, 32'(MD_out[i]), 32'h0);
      chk("rst_sel", i, 32'(rom_sel[i]), 32'h0);
    end
    chk_on = 1;
    @(negedge clk); rst_b = 1'b1;

    // Low-ROM read
    @(negedge clk); drive(23'h000123, 1'b1);
    repeat (3) @(negedge clk);
    chk("lo_dtack_ws0", 0, 32'(DTACK_b[0]), 32'h0);
    chk("lo_dtack_early", 1, 32'(DTACK_b[1]), 32'h1);
    @(negedge clk);
    chk("lo_dtack", 1, 32'(DTACK_b[1]), 32'h0);
    chk("lo_md", 1, 32'(MD_out[1]), 32'hBEEF);
    chk("lo_addr", 1, 32'(lrom_addr[1]), 32'h00123);
    repeat (2) @(negedge clk);
    chk("lo_dtack_ws3", 2, 32'(DTACK_b[2]), 32'h0);
    release_bus();
    @(negedge clk);
    chk("lo_dtack_rel", 1, 32'(DTACK_b[1]), 32'h1);
    chk("lo_md_hold", 1, 32'(MD_out[1]), 32'hBEEF);

    // High-ROM read
    drive(23'h040FFF, 1'b1);
    repeat (3) @(negedge clk);
    chk("hi_dtack", 0, 32'(DTACK_b[0]), 32'h0);
    chk("hi_md", 0, 32'(MD_out[0]), 32'h4E75);
    chk("hi_addr", 0, 32'(hrom_addr[0]), 32'hFFF);
    repeat (3) @(negedge clk);
    release_bus();
    @(negedge clk);

    // Out-of-region read
    drive(23'h080000, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("miss_dtack", 2, 32'(DTACK_b[2]), 32'h1);
      chk("miss_sel", 2, 32'(rom_sel[2]), 32'h0);
      chk("miss_en", 2, 32'(rom_en[2]), 32'h0);
    end
    release_bus();
    @(negedge clk);

    // Abort during WAIT (WAIT_STATES=3)
    drive(23'h000004, 1'b1);
    repeat (4) @(negedge clk);
    release_bus();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_dtack", 2, 32'(DTACK_b[2]), 32'h1);
    end
    chk("abort_sel", 2, 32'(rom_sel[2]), 32'h0);
    drive(23'h000002, 1'b1);
    repeat (6) @(negedge clk);
    chk("post_abort_dtack", 2, 32'(DTACK_b[2]), 32'h0);
    chk("post_abort_md", 2, 32'(MD_out[2]), 32'h5A58);
    release_bus();
    @(negedge clk);

    // Write to ROM region
    drive(23'h000010, 1'b0);
    repeat (6) @(negedge clk);
    chk("wr_dtack", 2, 32'(DTACK_b[2]), 32'h0);
    chk("wr_trap", 2, 32'(wr_trap[2]), 32'(TRAP_ON));
    chk("wr_md", 2, 32'(MD_out[2]), 32'h5A58);
    release_bus();
    repeat (3) @(negedge clk);
    chk("wr_trap_hold", 2, 32'(wr_trap[2]), 32'(TRAP_ON));
    BR_W_b = 1'b1;

    // Reset while in ACK
    drive(23'h000123, 1'b1);
    repeat (4) @(negedge clk);
    chk("pre_rst_dtack", 1, 32'(DTACK_b[1]), 32'h0);
    #2 rst_b = 1'b0;
    #1;
    chk("rst_ack_dtack", 1, 32'(DTACK_b[1]), 32'h1);
    chk("rst_ack_md", 1, 32'(MD_out[1]), 32'h0);
    chk("rst_ack_trap", 2, 32'(wr_trap[2]), 32'h0);
    @(negedge clk); release_bus();
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); drive(23'h040FFF, 1'b1);
    repeat (6) @(negedge clk);
    chk("post_rst_dtack", 2, 32'(DTACK_b[2]), 32'h0);
    chk("post_rst_md", 2, 32'(MD_out[2]), 32'h4E75);
    release_bus();
    @(negedge clk);

    // Randomized traffic against the model
    for (int t = 0; t < 300; t++) begin
      logic [22:0] a;
      int          hold, gap;
      a = 23'($urandom);
      if ($urandom_range(0, 3) != 0) a[22:19] = 4'h0;
      else if (a[22:19] == 4'h0) a[21] = 1'b1;
      addr   = a;
      BR_W_b = ($urandom_range(0, 3) != 0);
      UDS_b  = 1'($urandom);
      LDS_b  = 1'($urandom);
      AS_b   = 1'b0;
      hold   = $urandom_range(1, 9);
      gap    = $urandom_range(1, 3);
      repeat (hold) @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_b = 1'b0;
        @(negedge clk); rst_b = 1'b1;
      end
      release_bus();
      repeat (gap) @(negedge clk);
    end

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rom_bus_ctrl.md
# rom_bus_ctrl

Program-ROM bus slave between the 68010 bus of the `graphics` block and the on-chip program ROM arrays (high ROM 4K words, low ROM 128K words). Decodes the ROM region, drives synchronous BRAM addresses, inserts configurable wait states, returns read data on `MD_out` and generates `DTACK_b` with a full four-phase handshake against `AS_b`. It replaces the free-running, unhandshaked ROM reads at top level.

## Interface
Parameters:
- `WAIT_STATES`, 1: extra cycles between BRAM data valid and `DTACK_b` assertion, range 0–15.
- `HROM_AW`, 12: high-ROM word address width.
- `LROM_AW`, 17: low-ROM word address width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, the `MCKR` domain; all state changes on rising edge.
- `rst_b`  in  1  asynchronous active-low reset.
- `AS_b`  in  1  address strobe, active low.
- `UDS_b`, `LDS_b`  in  1 each  data strobes, active low.
- `BR_W_b`  in  1  1 = read, 0 = write.
- `addr`  in  23  word address (CPU A23:A1).
- `hrom_q`  in  16  high-ROM BRAM output, valid 1 cycle after `rom_en`.
- `lrom_q`  in  16  low-ROM BRAM output, valid 1 cycle after `rom_en`.
- `hrom_addr`  out  `HROM_AW`  high-ROM address.
- `lrom_addr`  out  `LROM_AW`  low-ROM address.
- `rom_en`  out  1  BRAM read enable, single-cycle pulse.
- `MD_out`  out  16  read data to CPU.
- `DTACK_b`  out  1  data acknowledge, active low.
- `rom_sel`  out  1  high while a ROM cycle is in progress (for bus muxing).
- `wr_trap`  out  1  sticky write-to-ROM flag (see Configuration).

## Operation
- Region hit: `addr[22:19] == 0`. `addr[18]` selects high ROM (`hrom_addr = addr[11:0]`); otherwise low ROM (`lrom_addr = addr[16:0]`).
- Cycle start condition, sampled in IDLE: `AS_b == 0`, region hit, and (`UDS_b == 0` or `LDS_b == 0`).
- FSM states: IDLE, FETCH, WAIT, ACK.
  - IDLE -> FETCH on the start condition. Latch the bank select and both addresses, pulse `rom_en`, set `rom_sel`.
  - FETCH -> WAIT when `WAIT_STATES > 0`, otherwise -> ACK. Register the selected `hrom_q`/`lrom_q` into the data latch.
  - WAIT: count down `WAIT_STATES` cycles, then -> ACK.
  - ACK: `DTACK_b = 0`, `MD_out` = latched data. Hold until `AS_b` is sampled high, then -> IDLE, `DTACK_b = 1`, `rom_sel = 0`.
- Writes (`BR_W_b == 0`) in the region: follow the same FSM and are acknowledged so the CPU does not hang. BRAM is not written and `MD_out` is unchanged.
- Abort: `AS_b` high in FETCH or WAIT -> IDLE next cycle, no DTACK.
- Region miss: no response. `DTACK_b` stays 1, `rom_sel` stays 0, `rom_en` stays 0.
- Back-to-back cycles need at least one IDLE cycle. A new cycle cannot start in the same edge that leaves ACK.

## Timing
- Reset values: `DTACK_b = 1`, `MD_out = 16'h0000`, `rom_en = 0`, `rom_sel = 0`, `hrom_addr = 0`, `lrom_addr = 0`, `wr_trap = 0`, FSM = IDLE, wait counter = 0.
- Read latency, from the edge sampling the start condition to the first edge with `DTACK_b = 0`: `2 + WAIT_STATES` cycles. `MD_out` is valid on that same edge and stable until `DTACK_b` rises.
- `DTACK_b` deasserts 1 cycle after `AS_b` is sampled high.
- `rst_b` low mid-cycle forces all outputs to their reset values immediately (asynchronous).
- `addr` and the strobes are already synchronous to `clk`; no synchronizers.

## Configuration
- `ROM_WRITE_TRAP_EN` defined:
  - A write in the region sets `wr_trap` on the FETCH edge; it stays set until reset.
  - The trapping address is held internally for debug probing.
  - The write is still acknowledged.
- Not defined: `wr_trap` is tied to 0 and no trap logic is synthesized.

## Structure
- Shared package `rom_bus_pkg`:
  - FSM state enum `rom_bus_state_t`.
  - Region constants `ROM_REGION_TAG = 4'h0`, `HROM_SEL_BIT = 18`.
  - Default widths.
- One sub-module `rom_wait_ctr`: loadable down-counter with a `done` flag, parameterized by width. The FSM stays in `rom_bus_ctrl`.

## Test plan
- Low-ROM read, `WAIT_STATES = 1`, `addr = 23'h000123`, `lrom_q = 16'hBEEF` -> `lrom_addr = 17'h00123`, `DTACK_b` low 3 cycles after `AS_b` is sampled low, `MD_out = 16'hBEEF`; `DTACK_b` high 1 cycle after `AS_b` rises.
- High-ROM read, `WAIT_STATES = 0`, `addr = 23'h040FFF`, `hrom_q = 16'h4E75` -> `hrom_addr = 12'hFFF`, `DTACK_b` low after 2 cycles, `MD_out = 16'h4E75`.
- Out-of-region read, `addr = 23'h080000` -> `DTACK_b`, `rom_sel` and `rom_en` stay inactive for 20 cycles.
- Abort: `AS_b` rises during WAIT with `WAIT_STATES = 3` -> no `DTACK_b` pulse, FSM back in IDLE; a following read at `addr = 23'h000002` completes normally.
- Write to `addr = 23'h000010` with `ROM_WRITE_TRAP_EN` defined -> `DTACK_b` asserted, `wr_trap = 1` and held, `MD_out` unchanged. Without the macro, `wr_trap` stays 0.
- `rst_b` pulsed low while in ACK -> `DTACK_b = 1` and `MD_out = 0` immediately. After release, the next read succeeds.
